state_display_scan: RTL and testbench

- Next-generation successor of the combinational state-to-7-segment decoder.
- Drives a multiplexed, NUM_DIGITS-wide common-anode display with a 4-character message per safelock state.
- Time-multiplexes the digits with a scan counter and blinks the message for alarm-class states.
- Sits between the safelock control FSM (i_state) and the board display pins.

---
 rtl/display_pkg.sv | 58 +++++
 rtl/glyph_rom.sv | 71 +++++++
 rtl/state_display_scan.sv | 100 ++++++++++
 tb/tb_state_display_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the safelock status display: glyph codes, their segment
// patterns, state codes and the set of states whose message blinks.
package display_pkg;

  typedef enum logic [4:0] {
    G_L, G_O, G_C, G_D, G_E, G_N, G_T, G_R,
    G_P, G_A, G_S, G_DASH, G_BLANK
  } glyph_e;

  // Segment order is {g,f,e,d,c,b,a}; active-low, so 1 = segment dark.
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned ST_LOCKED = 0;
  localparam int unsigned ST_ENTRY  = 1;
  localparam int unsigned ST_OPEN   = 2;
  localparam int unsigned ST_ERROR  = 3;
  localparam int unsigned ST_ALARM  = 4;
  localparam int unsigned ST_SET    = 5;

  localparam int unsigned MSG_LEN = 4;

  function automatic logic [6:0] glyph_seg(input glyph_e g);
    logic [6:0] seg;
    case (g)
      G_L:     seg = SEG_L;
      G_O:     seg = SEG_O;
      G_C:     seg = SEG_C;
      G_D:     seg = SEG_D;
      G_E:     seg = SEG_E;
      G_N:     seg = SEG_N;
      G_T:     seg = SEG_T;
      G_R:     seg = SEG_R;
      G_P:     seg = SEG_P;
      G_A:     seg = SEG_A;
      G_S:     seg = SEG_S;
      G_DASH:  seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic is_blink_class(input logic [31:0] st);
    return (st == ST_ERROR) || (st == ST_ALARM);
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// Combinational message table: (state, character position) -> segment pattern.
// Positions past the 4-character message and unknown states are handled here.
module glyph_rom
  import display_pkg::*;
#(
  parameter int STATE_W = 3
) (
  input  logic [STATE_W-1:0] state,
  input  logic [2:0]         char_idx,
  output logic [6:0]         seg
);

  logic [31:0] state_ext;
  glyph_e      glyph;

  assign state_ext = 32'(state);

  always_comb begin
    glyph = G_BLANK;
    if (32'(char_idx) < MSG_LEN) begin
      case (state_ext)
        ST_LOCKED:
          case (char_idx[1:0])
            2'd0:    glyph = G_L;
            2'd1:    glyph = G_O;
            2'd2:    glyph = G_C;
            default: glyph = G_D;
          endcase
        ST_ENTRY:
          case (char_idx[1:0])
            2'd0:    glyph = G_E;
            2'd1:    glyph = G_N;
            2'd2:    glyph = G_T;
            default: glyph = G_R;
          endcase
        ST_OPEN:
          case (char_idx[1:0])
            2'd0:    glyph = G_O;
            2'd1:    glyph = G_P;
            2'd2:    glyph = G_E;
            default: glyph = G_N;
          endcase
        ST_ERROR:
          case (char_idx[1:0])
            2'd0:    glyph = G_E;
            2'd1:    glyph = G_R;
            2'd2:    glyph = G_R;
            default: glyph = G_BLANK;
          endcase
        ST_ALARM:
          case (char_idx[1:0])
            2'd0:    glyph = G_A;
            2'd1:    glyph = G_L;
            2'd2:    glyph = G_R;
            default: glyph = G_BLANK;
          endcase
        ST_SET:
          case (char_idx[1:0])
            2'd0:    glyph = G_S;
            2'd1:    glyph = G_E;
            2'd2:    glyph = G_T;
            default: glyph = G_BLANK;
          endcase
        default: glyph = G_DASH;
      endcase
    end
  end

  assign seg = glyph_seg(glyph);

endmodule

// File: rtl/state_display_scan.sv
// Multiplexed common-anode display driver for the safelock state: scans digits,
// looks up each character, and blinks the message in alarm-class states.
module state_display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STATE_W    = 3,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [STATE_W-1:0]    i_state,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [6:0]            o_7seg
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [STATE_W-1:0]    state_q;
  logic [SCAN_W-1:0]     scan_cnt_reg;
  logic [DIG_W-1:0]      digit_idx_reg;
  logic [BLINK_W-1:0]    blink_cnt_reg;
  logic                  blink_on_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]            seg_reg;

  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            glyph_bits;
  logic [6:0]            seg_next;
  logic [2:0]            char_idx;
  logic                  scan_wrap;
  logic                  digit_last;
  logic                  blink_wrap;
  logic                  blanked;

  assign scan_wrap  = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
  assign digit_last = (digit_idx_reg == DIG_W'(NUM_DIGITS - 1));
  assign blink_wrap = (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1));
  assign char_idx   = 3'(digit_idx_reg);

  // Character k is the k-th digit from the left, i.e. anode NUM_DIGITS-1-k.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = (digit_idx_reg != DIG_W'(NUM_DIGITS - 1 - gi));
    end
  endgenerate

  glyph_rom #(
    .STATE_W (STATE_W)
  ) u_glyph_rom (
    .state    (state_q),
    .char_idx (char_idx),
    .seg      (glyph_bits)
  );

  assign blanked  = is_blink_class(32'(state_q)) && !blink_on_reg;
  assign seg_next = blanked ? SEG_BLANK : glyph_bits;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= '0;
      scan_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
      an_reg        <= '1;
      seg_reg       <= SEG_BLANK;
    end else begin
      state_q <= i_state;
      if (i_en) begin
        scan_cnt_reg <= scan_wrap ? '0 : scan_cnt_reg + 1'b1;
        if (scan_wrap) begin
          digit_idx_reg <= digit_last ? '0 : digit_idx_reg + 1'b1;
        end
        blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
        if (blink_wrap) begin
          blink_on_reg <= !blink_on_reg;
        end
        an_reg  <= an_next;
        seg_reg <= seg_next;
      end else begin
        an_reg  <= '1;
        seg_reg <= SEG_BLANK;
      end
      // A new state restarts the blink phase so its message shows at once.
      if (state_q != i_state) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end
    end
  end

  assign o_an   = an_reg;
  assign o_7seg = seg_reg;

endmodule

// File: tb/tb_state_display_scan.sv
// Scoreboard bench: the driver predicts each cycle's display from a message-table
// reference model and queues it; a negedge monitor pops and compares.
module tb_state_display_scan;

  localparam int NUM_DIGITS = 4;
  localparam int STATE_W    = 3;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [STATE_W-1:0]    state;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [10:0] exp_q[$];

  // reference model state
  int          m_state;
  int          m_scan;
  int          m_blink;
  string       msgs[8] = '{"LOCd", "Entr", "OPEn", "Err ", "ALr ", "SEt ", "----", "----"};

  state_display_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .STATE_W    (STATE_W),
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_state (state),
    .o_an    (an),
    .o_7seg  (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] char_seg(input byte c);
    case (c)
      "L":     return 7'b1000111;
      "O":     return 7'b1000000;
      "C":     return 7'b1000110;
      "d":     return 7'b0100001;
      "E":     return 7'b0000110;
      "n":     return 7'b0101011;
      "t":     return 7'b0000111;
      "r":     return 7'b0101111;
      "P":     return 7'b0001100;
      "A":     return 7'b0001000;
      "S":     return 7'b0010010;
      "-":     return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_scan  = 0;
    m_blink = 0;
  endtask

  // Drive one cycle of inputs, queue the display expected after the next edge.
  task automatic step(input logic e, input int st);
    int          digit;
    logic        dark;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    en    = e;
    state = STATE_W'(st);
    digit = (m_scan / SCAN_DIV) % NUM_DIGITS;
    dark  = ((m_state == 3) || (m_state == 4)) && (((m_blink / BLINK_DIV) % 2) == 1);
    if (e) begin
      exp_an = 4'b1111;
      exp_an[NUM_DIGITS - 1 - digit] = 1'b0;
      exp_seg = (dark || digit >= 4) ? 7'b1111111 : char_seg(msgs[m_state][digit]);
    end else begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
    end
    exp_q.push_back({exp_an, exp_seg});
    if (e) begin
      m_scan++;
      m_blink++;
    end
    if (st != m_state) m_blink = 0;
    m_state = st;
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
               name, act[10:7], act[6:0], req[10:7], req[6:0]);
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL txn %0d: got an=%b seg=%b, expected an=%b seg=%b",
                 txn, an, seg, e[10:7], e[6:0]);
      end else begin
        $display("txn %0d ok an=%b seg=%b", txn, an, seg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    state = '0;
    model_reset();
    #22;
    check_now("reset_state", {an, seg}, {4'b1111, 7'b1111111});
    rst_n = 1'b1;
    #1;
    check_now("pre_first_clock", {an, seg}, {4'b1111, 7'b1111111});

    // 1: LOCd scan with explicit spot checks
    step(1'b1, 0);
    check_now("first_digit_L", {an, seg}, {4'b0111, 7'b1000111});
    for (int i = 0; i < 4; i++) step(1'b1, 0);
    check_now("second_digit_O", {an, seg}, {4'b1011, 7'b1000000});
    for (int i = 0; i < 15; i++) step(1'b1, 0);

    // 2: OPEn, never blinks
    for (int i = 0; i < 16; i++) step(1'b1, 2);

    // 3: ALr blinking, then 4: change to LOCd in a dark phase
    for (int i = 0; i < 84; i++) step(1'b1, 4);
    for (int i = 0; i < 8; i++) step(1'b1, 0);

    // 6: asynchronous reset between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_blank", {an, seg}, {4'b1111, 7'b1111111});
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 0);
    check_now("restart_digit0", {an, seg}, {4'b0111, 7'b1000111});

    // 5: disable mid-slot at digit 2, then resume
    for (int i = 0; i < 8; i++) step(1'b1, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1);
    check_now("disabled_blank", {an, seg}, {4'b1111, 7'b1111111});
    for (int i = 0; i < 12; i++) step(1'b1, 1);

    // out-of-range states, ERROR blink
    for (int i = 0; i < 20; i++) step(1'b1, 7);
    for (int i = 0; i < 40; i++) step(1'b1, 3);
    for (int i = 0; i < 20; i++) step(1'b1, 6);

    // randomized holds with occasional disable
    for (int seg_i = 0; seg_i < 40; seg_i++) begin
      int st;
      int len;
      st  = $urandom_range(0, 7);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) step(($urandom_range(0, 9) != 0), st);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
